// File: rtl/display_pkg.sv
// Shared types and constants for the display test-pattern source.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT_HI = 2'd1,
    EMIT_LO = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] PAT_SOLID    = 2'd0;
  localparam logic [1:0] PAT_BARS     = 2'd1;
  localparam logic [1:0] PAT_CHECKER  = 2'd2;
  localparam logic [1:0] PAT_GRADIENT = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // RGB565 colour of a bar, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/display_pattern_color.sv
// Combinational pixel colour for the selected pattern.
// x carries pixel x[8:4], y carries pixel y[7:2]; only those bits affect any pattern.
module display_pattern_color
  import display_pkg::*;
(
  input  logic [1:0]  pattern,
  input  logic [4:0]  x,
  input  logic [5:0]  y,
  input  logic [2:0]  bar_idx,
  input  logic [15:0] solid_color,
  output logic [15:0] color_c
);

  always_comb begin
    color_c = 16'h0000;
    case (pattern)
      PAT_SOLID:    color_c = solid_color;
      PAT_BARS:     color_c = bar_color(bar_idx);
      PAT_CHECKER:  color_c = (x[0] ^ y[2]) ? 16'h0000 : 16'hFFFF;
      PAT_GRADIENT: color_c = {x, y, 5'b00000};
      default:      color_c = 16'h0000;
    endcase
  end

endmodule

// File: rtl/display_pattern_source.sv
// Streams one RGB565 test-pattern frame per frame_start as a valid/ready byte stream,
// high byte first, scanning pixels left to right and top to bottom.
module display_pattern_source
  import display_pkg::*;
#(
  parameter int unsigned DIS_RES_X = 320,
  parameter int unsigned DIS_RES_Y = 240,
  parameter int unsigned BAR_COUNT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned XW    = (DIS_RES_X > 1) ? $clog2(DIS_RES_X) : 1;
  localparam int unsigned YW    = (DIS_RES_Y > 1) ? $clog2(DIS_RES_Y) : 1;
  localparam int unsigned BAR_W = DIS_RES_X / BAR_COUNT;
  localparam int unsigned BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned BW    = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(DIS_RES_X - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(DIS_RES_Y - 1);
  localparam logic [BPW-1:0] BP_LAST = BPW'(BAR_W - 1);
  localparam logic [BW-1:0]  B_LAST  = BW'(BAR_COUNT - 1);

  state_e         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [BPW-1:0] bar_px_q, bar_px_d;
  logic [BW-1:0]  bar_q, bar_d;
  logic [1:0]     pattern_q, pattern_d;
  logic [15:0]    solid_q, solid_d;
  logic           byte_valid_q, byte_valid_d;
  logic [7:0]     byte_data_q, byte_data_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    color_c;

  // Colour of the pixel the next state will present.
  display_pattern_color u_color (
    .pattern     (pattern_d),
    .x           (5'(x_d >> 4)),
    .y           (6'(y_d >> 2)),
    .bar_idx     (3'(bar_d)),
    .solid_color (solid_d),
    .color_c     (color_c)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_px_d  = bar_px_q;
    bar_d     = bar_q;
    pattern_d = pattern_q;
    solid_d   = solid_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = EMIT_HI;
          pattern_d = pattern_sel;
          solid_d   = solid_color;
          x_d       = '0;
          y_d       = '0;
          bar_px_d  = '0;
          bar_d     = '0;
        end
      end
      EMIT_HI: begin
        if (byte_ready) state_d = EMIT_LO;
      end
      EMIT_LO: begin
        if (byte_ready) begin
          state_d = EMIT_HI;
          if (x_q == X_LAST) begin
            x_d      = '0;
            bar_px_d = '0;
            bar_d    = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = DONE;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
            // Bar tracking replaces a divide of x by the bar width.
            if (bar_px_q == BP_LAST) begin
              bar_px_d = '0;
              bar_d    = (bar_q == B_LAST) ? '0 : bar_q + BW'(1);
            end else begin
              bar_px_d = bar_px_q + BPW'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    byte_valid_d = (state_d == EMIT_HI) || (state_d == EMIT_LO);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    byte_data_d  = 8'h00;
    if (state_d == EMIT_HI) byte_data_d = color_c[15:8];
    if (state_d == EMIT_LO) byte_data_d = color_c[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      bar_px_q     <= '0;
      bar_q        <= '0;
      pattern_q    <= '0;
      solid_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bar_px_q     <= bar_px_d;
      bar_q        <= bar_d;
      pattern_q    <= pattern_d;
      solid_q      <= solid_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_pattern_source.sv
// Scoreboard bench for display_pattern_source with a short 320x8 frame.
module tb_display_pattern_source;

  localparam int RES_X       = 320;
  localparam int RES_Y       = 8;
  localparam int FRAME_BYTES = 2 * RES_X * RES_Y;
  localparam int STALL_AT    = 21;
  localparam int TIMEOUT     = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        byte_ready = 1'b1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap [FRAME_BYTES];
  int xfer_total = 0;
  int frame_base = 0;
  int done_cnt   = 0;
  int done_base  = 0;
  int bp_mode    = 0;
  int stall_left = 0;
  int stall_base = -1;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  display_pattern_source #(
    .DIS_RES_X (RES_X),
    .DIS_RES_Y (RES_Y),
    .BAR_COUNT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pattern_sel (pattern_sel),
    .solid_color (solid_color),
    .byte_ready  (byte_ready),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_color(input logic [1:0] pat, input logic [15:0] solid,
                                              input int x, input int y);
    logic [8:0]  xv;
    logic [7:0]  yv;
    logic [15:0] c;
    xv = 9'(x);
    yv = 8'(y);
    case (pat)
      2'd0: c = solid;
      2'd1: begin
        case ((x / (RES_X / 8)) % 8)
          0: c = 16'hFFFF;
          1: c = 16'hFFE0;
          2: c = 16'h07FF;
          3: c = 16'h07E0;
          4: c = 16'hF81F;
          5: c = 16'hF800;
          6: c = 16'h001F;
          default: c = 16'h0000;
        endcase
      end
      2'd2: c = (xv[4] ^ yv[4]) ? 16'h0000 : 16'hFFFF;
      default: c = {xv[8:4], yv[7:2], 5'b00000};
    endcase
    return c;
  endfunction

  // Drives byte_ready and scores every accepted byte against the expected queue.
  always @(negedge clk) begin
    int fidx;
    logic [7:0] e;
    if (!reset) begin
      exp_q.delete();
      stall_left = 0;
      byte_ready = 1'b1;
      hold_prev  = 1'b0;
    end else begin
      if (frame_done) done_cnt++;
      if (hold_prev) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_data", 32'(byte_data), 32'(hold_data));
      end
      fidx = xfer_total - frame_base;
      if (bp_mode == 2 && byte_valid && fidx == STALL_AT && stall_base != frame_base) begin
        stall_left = 5;
        stall_base = frame_base;
      end
      if (stall_left > 0) begin
        byte_ready = 1'b0;
        stall_left--;
      end else if (bp_mode == 1) begin
        byte_ready = 1'($urandom_range(0, 1));
      end else begin
        byte_ready = 1'b1;
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_byte", 32'(byte_data), 32'(e));
        end
        if (fidx >= 0 && fidx < FRAME_BYTES) cap[fidx] = byte_data;
        xfer_total++;
      end
      hold_prev = byte_valid && !byte_ready;
      hold_data = byte_data;
    end
  end

  task automatic start_frame(input logic [1:0] pat, input logic [15:0] col, input int mode);
    logic [15:0] c;
    @(posedge clk); #2;
    bp_mode    = mode;
    frame_base = xfer_total;
    done_base  = done_cnt;
    for (int y = 0; y < RES_Y; y++) begin
      for (int x = 0; x < RES_X; x++) begin
        c = model_color(pat, col, x, y);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
      end
    end
    pattern_sel = pat;
    solid_color = col;
    frame_start = 1'b1;
    @(posedge clk); #2;
    frame_start = 1'b0;
    pattern_sel = pat + 2'd1;
    solid_color = ~col;
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while ((xfer_total - frame_base) < n && k < TIMEOUT) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("byte_progress", 32'((xfer_total - frame_base) >= n), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == done_base && k < TIMEOUT) begin
      @(posedge clk);
      k++;
    end
    check("frame_done_seen", 32'(done_cnt), 32'(done_base + 1));
    repeat (3) @(posedge clk);
    #2;
    check("single_done", 32'(done_cnt), 32'(done_base + 1));
    check("frame_bytes", 32'(xfer_total - frame_base), 32'(FRAME_BYTES));
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(byte_valid), 32'd0);
  endtask

  initial begin
    // Reset held with frame_start high must leave the block idle.
    reset       = 1'b0;
    frame_start = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    frame_start = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_data", 32'(byte_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(byte_valid), 32'd0);

    start_frame(2'd0, 16'h1234, 0);
    #1;
    check("solid_busy", 32'(busy), 32'd1);
    wait_done();
    check("solid_b0", 32'(cap[0]), 32'h12);
    check("solid_b1", 32'(cap[1]), 32'h34);

    // Bars with a 5-cycle low-byte stall and an ignored mid-frame frame_start.
    start_frame(2'd1, 16'h0000, 2);
    wait_bytes(300);
    frame_start = 1'b1;
    pattern_sel = 2'd3;
    solid_color = 16'h0000;
    @(posedge clk); #2;
    frame_start = 1'b0;
    wait_done();
    check("bar_p0_hi", 32'(cap[0]), 32'hFF);
    check("bar_p0_lo", 32'(cap[1]), 32'hFF);
    check("bar_p40_hi", 32'(cap[80]), 32'hFF);
    check("bar_p40_lo", 32'(cap[81]), 32'hE0);
    check("bar_p319_hi", 32'(cap[638]), 32'h00);
    check("bar_p319_lo", 32'(cap[639]), 32'h00);
    check("bar_p320_hi", 32'(cap[640]), 32'hFF);
    check("bar_p320_lo", 32'(cap[641]), 32'hFF);

    start_frame(2'd2, 16'h0000, 1);
    wait_done();
    check("chk_p16_hi", 32'(cap[32]), 32'h00);

    start_frame(2'd3, 16'h0000, 0);
    wait_done();

    // Reset mid-frame aborts silently; the next frame restarts at pixel (0,0).
    start_frame(2'd1, 16'h0000, 0);
    wait_bytes(1000);
    done_base = done_cnt;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(done_base));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(byte_valid), 32'd0);
    start_frame(2'd0, 16'hA5C3, 0);
    wait_done();
    check("restart_b0", 32'(cap[0]), 32'hA5);
    check("restart_b1", 32'(cap[1]), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
